// File: rtl/fll_cfg_arbiter.sv
// Round-robin arbiter sharing the FLL configuration port between several requesters,
// with timeout protection on both handshake phases and a synchronised lock status.
module fll_cfg_arbiter #(
    parameter int NB_REQ     = 2,
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NB_REQ-1:0]              req_i,
    input  logic [NB_REQ-1:0]              wrn_i,
    input  logic [NB_REQ*ADDR_WIDTH-1:0]   add_i,
    input  logic [NB_REQ*DATA_WIDTH-1:0]   wdata_i,
    output logic [NB_REQ-1:0]              ack_o,
    output logic [NB_REQ-1:0]              err_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           busy_o,
    output logic                           fll_req_o,
    output logic                           fll_wrn_o,
    output logic [ADDR_WIDTH-1:0]          fll_add_o,
    output logic [DATA_WIDTH-1:0]          fll_data_o,
    input  logic                           fll_ack_i,
    input  logic [DATA_WIDTH-1:0]          fll_r_data_i,
    input  logic                           fll_lock_i,
    output logic                           lock_o,
    output logic                           lock_lost_o
);

    localparam int IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] REQ_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] REL_LIMIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, ACKLOW} state_t;

    state_t            state;
    logic [IDX_W-1:0]  gnt;
    logic [IDX_W-1:0]  last;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W:0]    cand;
    logic [NB_REQ-1:0] served;
    logic [NB_REQ-1:0] eligible;
    logic              any_elig;
    logic [CNT_W-1:0]  cnt;
    logic              lock_s1;
    logic              lock_d;

    assign eligible = req_i & ~served;

    // Search starts just after the last winner and wraps, so each pending requester
    // waits behind at most NB_REQ-1 others.
    always_comb begin
        any_elig = 1'b0;
        winner   = '0;
        cand     = '0;
        for (int i = 1; i <= NB_REQ; i++) begin
            cand = {1'b0, last} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NB_REQ)) begin
                cand = cand - (IDX_W+1)'(NB_REQ);
            end
            if (!any_elig && eligible[cand[IDX_W-1:0]]) begin
                any_elig = 1'b1;
                winner   = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            fll_req_o  <= 1'b0;
            fll_wrn_o  <= 1'b1;
            fll_add_o  <= '0;
            fll_data_o <= '0;
            ack_o      <= '0;
            err_o      <= '0;
            rdata_o    <= '0;
            busy_o     <= 1'b0;
            served     <= '0;
            last       <= IDX_W'(NB_REQ - 1);
            gnt        <= '0;
            cnt        <= '0;
        end else begin
            ack_o  <= '0;
            err_o  <= '0;
            // A served requester becomes eligible again only after dropping its request.
            served <= served & req_i;
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        gnt        <= winner;
                        last       <= winner;
                        fll_wrn_o  <= wrn_i[winner];
                        fll_add_o  <= add_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
                        fll_data_o <= wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
                        fll_req_o  <= 1'b1;
                        busy_o     <= 1'b1;
                        cnt        <= '0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (fll_ack_i) begin
                        fll_req_o   <= 1'b0;
                        if (fll_wrn_o) begin
                            rdata_o <= fll_r_data_i;
                        end
                        ack_o[gnt]  <= 1'b1;
                        served[gnt] <= 1'b1;
                        cnt         <= '0;
                        state       <= ACKLOW;
                    end else if (cnt == REQ_LIMIT) begin
                        fll_req_o   <= 1'b0;
                        rdata_o     <= '0;
                        ack_o[gnt]  <= 1'b1;
                        err_o[gnt]  <= 1'b1;
                        served[gnt] <= 1'b1;
                        cnt         <= '0;
                        state       <= ACKLOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACKLOW: begin
                    // A stuck-high FLL ack must not lock the port forever.
                    if (!fll_ack_i || cnt == REL_LIMIT) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Lock status runs independently of the transaction FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_s1     <= 1'b0;
            lock_o      <= 1'b0;
            lock_d      <= 1'b0;
            lock_lost_o <= 1'b0;
        end else begin
            lock_s1     <= fll_lock_i;
            lock_o      <= lock_s1;
            lock_d      <= lock_o;
            lock_lost_o <= lock_d & ~lock_o;
        end
    end

endmodule

// File: tb/tb_fll_cfg_arbiter.sv
// Bench for fll_cfg_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model compared on every cycle.
module tb_fll_cfg_arbiter;

    localparam int NB = 2;
    localparam int AW = 2;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NB-1:0]     req;
    logic [NB-1:0]     wrn;
    logic [NB*AW-1:0]  add;
    logic [NB*DW-1:0]  wdata;
    logic              fll_ack;
    logic [DW-1:0]     fll_rdata;
    logic              fll_lock;
    logic [NB-1:0]     ack_o;
    logic [NB-1:0]     err_o;
    logic [DW-1:0]     rdata_o;
    logic              busy_o;
    logic              fll_req_o;
    logic              fll_wrn_o;
    logic [AW-1:0]     fll_add_o;
    logic [DW-1:0]     fll_data_o;
    logic              lock_o;
    logic              lock_lost_o;

    fll_cfg_arbiter #(.NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .wrn_i(wrn), .add_i(add), .wdata_i(wdata),
        .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o),
        .fll_req_o(fll_req_o), .fll_wrn_o(fll_wrn_o), .fll_add_o(fll_add_o),
        .fll_data_o(fll_data_o), .fll_ack_i(fll_ack), .fll_r_data_i(fll_rdata),
        .fll_lock_i(fll_lock), .lock_o(lock_o), .lock_lost_o(lock_lost_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected outputs for the cycle that begins at each rising edge.
    logic          m_valid = 1'b0;
    logic [NB-1:0] e_ack, e_err;
    logic [DW-1:0] e_rdata, e_fdata;
    logic          e_busy, e_freq, e_fwrn, e_lock, e_lost;
    logic [AW-1:0] e_fadd;

    initial begin
        int            cyc;
        int            phase;     // 0 port free, 1 FLL request out, 2 awaiting FLL release
        int            t_start;   // cycle in which the current phase began
        int            owner;
        int            last;
        logic [NB-1:0] served;
        logic [NB-1:0] elig;
        logic [3:0]    hist;
        cyc = 0; phase = 0; t_start = 0; owner = 0; last = NB - 1; served = '0; hist = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_valid = 1'b1;
                phase = 0; last = NB - 1; served = '0; hist = '0;
                e_freq = 1'b0; e_fwrn = 1'b1; e_fadd = '0; e_fdata = '0;
                e_ack = '0; e_err = '0; e_rdata = '0; e_busy = 1'b0;
                e_lock = 1'b0; e_lost = 1'b0;
            end else begin
                e_ack = '0;
                e_err = '0;
                hist   = {hist[2:0], fll_lock};
                e_lock = hist[1];
                e_lost = hist[3] & ~hist[2];
                elig   = req & ~served;
                served = served & req;
                if (phase == 0) begin
                    bit found;
                    found = 1'b0;
                    for (int i = 1; i <= NB; i++) begin
                        int k;
                        k = (last + i) % NB;
                        if (!found && elig[k]) begin
                            found = 1'b1;
                            owner = k;
                        end
                    end
                    if (found) begin
                        last    = owner;
                        e_fwrn  = wrn[owner];
                        e_fadd  = add[owner*AW +: AW];
                        e_fdata = wdata[owner*DW +: DW];
                        e_freq  = 1'b1;
                        e_busy  = 1'b1;
                        phase   = 1;
                        t_start = cyc + 1;
                    end
                end else if (phase == 1) begin
                    if (fll_ack) begin
                        e_freq = 1'b0;
                        e_ack[owner] = 1'b1;
                        if (e_fwrn) e_rdata = fll_rdata;
                        served[owner] = 1'b1;
                        phase = 2;
                        t_start = cyc + 1;
                    end else if ((cyc + 1) - t_start == TO + 1) begin
                        e_freq = 1'b0;
                        e_ack[owner] = 1'b1;
                        e_err[owner] = 1'b1;
                        e_rdata = '0;
                        served[owner] = 1'b1;
                        phase = 2;
                        t_start = cyc + 1;
                    end
                end else begin
                    if (!fll_ack || ((cyc + 1) - t_start == TO)) begin
                        phase  = 0;
                        e_busy = 1'b0;
                    end
                end
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("ack_o", ack_o, e_ack);
                chk("err_o", err_o, e_err);
                chk("rdata_o", rdata_o, e_rdata);
                chk("busy_o", busy_o, e_busy);
                chk("fll_req_o", fll_req_o, e_freq);
                chk("fll_wrn_o", fll_wrn_o, e_fwrn);
                chk("fll_add_o", fll_add_o, e_fadd);
                chk("fll_data_o", fll_data_o, e_fdata);
                chk("lock_o", lock_o, e_lock);
                chk("lock_lost_o", lock_lost_o, e_lost);
            end
        end
    end

    initial begin
        int   g;
        int   lost_cnt;
        logic prev_freq, dead, stuck;
        rst_n = 1'b0; req = '0; wrn = '0; add = '0; wdata = '0;
        fll_ack = 1'b0; fll_rdata = '0; fll_lock = 1'b0;
        tick(); tick();
        chk("rst_fll_wrn", fll_wrn_o, 1'b1);
        chk("rst_fll_req", fll_req_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_ack", ack_o, 2'b00);
        rst_n = 1'b1;
        tick();

        // Single write from requester 0.
        wrn[0] = 1'b0; add[1:0] = 2'd2; wdata[31:0] = 32'h1234_5678; req[0] = 1'b1;
        tick();
        chk("wr_fll_req", fll_req_o, 1'b1);
        chk("wr_fll_add", fll_add_o, 2'd2);
        chk("wr_fll_data", fll_data_o, 32'h1234_5678);
        chk("wr_fll_wrn", fll_wrn_o, 1'b0);
        repeat (3) tick();
        fll_ack = 1'b1;
        tick();
        chk("wr_ack", ack_o, 2'b01);
        chk("wr_err", err_o, 2'b00);
        chk("wr_rdata", rdata_o, 32'h0);
        chk("wr_fll_req_low", fll_req_o, 1'b0);
        req[0] = 1'b0; fll_ack = 1'b0;
        tick();
        chk("wr_ack_gone", ack_o, 2'b00);
        chk("wr_idle", busy_o, 1'b0);

        // Read from requester 1.
        wrn[1] = 1'b1; add[3:2] = 2'd1; req[1] = 1'b1;
        tick();
        chk("rd_fll_req", fll_req_o, 1'b1);
        chk("rd_fll_add", fll_add_o, 2'd1);
        fll_ack = 1'b1; fll_rdata = 32'hCAFE_0001;
        tick();
        chk("rd_ack", ack_o, 2'b10);
        chk("rd_rdata", rdata_o, 32'hCAFE_0001);
        req[1] = 1'b0; fll_ack = 1'b0;
        tick();

        // Contention: both held, each re-requesting after its ack.
        wrn = 2'b11; req = 2'b11; g = 0;
        for (int c = 0; c < 200 && g < 4; c++) begin
            tick();
            fll_ack = fll_req_o;
            fll_rdata = $urandom | 32'h1;
            if (ack_o != '0) begin
                chk("rr_order", ack_o, 2'b01 << (g % 2));
                g++;
            end
            for (int k = 0; k < NB; k++) begin
                if (ack_o[k]) req[k] = 1'b0;
                else if (!req[k]) req[k] = 1'b1;
            end
        end
        req = '0;
        chk("rr_count", g, 4);
        fll_ack = 1'b0;
        tick(); tick();

        // Timeout with a dead FLL.
        req[0] = 1'b1;
        tick();
        chk("to_fll_req", fll_req_o, 1'b1);
        repeat (8) tick();
        chk("to_not_yet", ack_o, 2'b00);
        tick();
        chk("to_ack", ack_o, 2'b01);
        chk("to_err", err_o, 2'b01);
        chk("to_rdata", rdata_o, 32'h0);
        chk("to_fll_req_low", fll_req_o, 1'b0);
        req[0] = 1'b0;
        tick();

        // FLL ack stuck high: release phase gives up after TO cycles.
        fll_ack = 1'b1; req[1] = 1'b1;
        tick(); tick();
        chk("stk_ack", ack_o, 2'b10);
        req[1] = 1'b0;
        repeat (7) tick();
        chk("stk_busy", busy_o, 1'b1);
        tick();
        chk("stk_idle", busy_o, 1'b0);
        fll_ack = 1'b0;
        tick();

        // Reset in the middle of a request.
        add[1:0] = 2'd1; add[3:2] = 2'd3; req[1] = 1'b1;
        tick();
        chk("mr_add", fll_add_o, 2'd3);
        rst_n = 1'b0;
        tick();
        chk("mr_fll_req", fll_req_o, 1'b0);
        chk("mr_ack", ack_o, 2'b00);
        chk("mr_busy", busy_o, 1'b0);
        chk("mr_fll_wrn", fll_wrn_o, 1'b1);
        rst_n = 1'b1; req = 2'b11;
        tick();
        chk("mr_prio0", fll_add_o, 2'd1);
        fll_ack = 1'b1;
        tick();
        chk("mr_ack0", ack_o, 2'b01);
        req = '0; fll_ack = 1'b0;
        tick(); tick();

        // Lock synchroniser and loss pulse.
        fll_lock = 1'b1;
        tick();
        chk("lk_lat1", lock_o, 1'b0);
        tick();
        chk("lk_rise", lock_o, 1'b1);
        fll_lock = 1'b0;
        lost_cnt = 0;
        for (int c = 3; c <= 7; c++) begin
            tick();
            if (lost_cnt == 0 && c < 5) chk("lk_early", lock_lost_o, 1'b0);
            if (c == 5) chk("lk_lost", lock_lost_o, 1'b1);
            if (lock_lost_o) lost_cnt++;
        end
        chk("lk_once", lost_cnt, 1);

        // Randomized traffic.
        prev_freq = 1'b0; dead = 1'b0; stuck = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            rst_n = ($urandom_range(0, 299) != 0);
            if (fll_req_o && !prev_freq) dead = ($urandom_range(0, 7) == 0);
            prev_freq = fll_req_o;
            if (fll_req_o && !fll_ack) begin
                if (!dead && $urandom_range(0, 3) == 0) begin
                    fll_ack = 1'b1;
                    stuck = ($urandom_range(0, 9) == 0);
                end
            end else if (!fll_req_o && fll_ack) begin
                fll_ack = stuck ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 1) == 1);
            end
            fll_rdata = $urandom;
            for (int k = 0; k < NB; k++) begin
                if (req[k] && ack_o[k]) begin
                    req[k] = 1'b0;
                end else if (!req[k] && $urandom_range(0, 3) == 0) begin
                    req[k] = 1'b1;
                    wrn[k] = $urandom_range(0, 1);
                    add[k*AW +: AW] = AW'($urandom);
                    wdata[k*DW +: DW] = $urandom;
                end else if (req[k] && $urandom_range(0, 63) == 0) begin
                    req[k] = 1'b0;
                end
            end
            if ($urandom_range(0, 19) == 0) fll_lock = ~fll_lock;
        end
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
